// File: rtl/pc_fetch_unit.sv
// Program-counter / fetch sequencer: stall, imem back-pressure, branch/JALR redirect,
// misaligned-target trap and a saturating accepted-fetch counter. Optional macro: PC_TRAP_VEC_EN.
module pc_fetch_unit #(
  parameter int                   PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = 'h0,
  parameter logic [PC_WIDTH-1:0]  TRAP_VECTOR  = 'h40,
  parameter int                   COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   imem_ready,
  input  logic [1:0]             PCsrc,
  input  logic [PC_WIDTH-1:0]    PC_Target,
  output logic [PC_WIDTH-1:0]    PC,
  output logic [PC_WIDTH-1:0]    PC_plus4,
  output logic                   fetch_valid,
  output logic                   misalign,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD, TRAP} state_t;

  state_t                state;
  logic                  accept;
  logic                  redirect;
  logic                  tgt_misaligned;
  logic [PC_WIDTH-1:0]   target;

  assign PC_plus4 = PC + PC_WIDTH'(4);

  always_comb begin
    accept         = fetch_valid & imem_ready & ~stall;
    redirect       = fetch_valid & ((PCsrc == 2'b01) | (PCsrc == 2'b10));
    target         = (PCsrc == 2'b01) ? (PC + PC_Target) : {PC_Target[PC_WIDTH-1:1], 1'b0};
    tgt_misaligned = (target[1:0] != 2'b00);
  end

  // fetch_valid is only ever high in RUN/HOLD, so accept and redirect are inert in BOOT/TRAP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      PC          <= RESET_VECTOR;
      state       <= BOOT;
      fetch_valid <= 1'b0;
      misalign    <= 1'b0;
      fetch_count <= '0;
    end else begin
`ifdef PC_TRAP_VEC_EN
      misalign <= 1'b0;
`endif
      if (accept && (fetch_count != {COUNT_WIDTH{1'b1}}))
        fetch_count <= fetch_count + 1'b1;
      case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN, HOLD: begin
          if (redirect && tgt_misaligned) begin
`ifdef PC_TRAP_VEC_EN
            PC          <= TRAP_VECTOR;
            state       <= RUN;
            misalign    <= 1'b1;
`else
            state       <= TRAP;
            fetch_valid <= 1'b0;
            misalign    <= 1'b1;
`endif
          end else if (redirect) begin
            PC    <= target;
            state <= RUN;
          end else if (accept) begin
            PC    <= PC_plus4;
            state <= RUN;
          end else begin
            state <= HOLD;
          end
        end
        default: begin
          // TRAP: frozen until reset.
          state <= TRAP;
        end
      endcase
    end
  end

endmodule
